mult_iter_unit: RTL



---
 rtl/mult_pkg.sv | 27 ++
 rtl/mult_iter_unit_if.sv | 25 ++
 rtl/booth_r4_sel.sv | 25 ++
 rtl/fifo.sv | 81 ++++++++
 rtl/mult_iter_unit.sv | 115 +++++++++++
 5 files changed

// File: rtl/mult_pkg.sv
// Shared types and constants for the iterative radix-4 Booth multiplier.
package mult_pkg;

  typedef enum logic [1:0] {
    MULT_MUL    = 2'b00,
    MULT_MULH   = 2'b01,
    MULT_MULHSU = 2'b10,
    MULT_MULHU  = 2'b11
  } mult_cmd_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_CALC = 2'b01,
    ST_DONE = 2'b10
  } mult_state_t;

  // Booth groups {b[2i+1], b[2i], b[2i-1]} and the multiple of op1 they select.
  localparam logic [2:0] BOOTH_ZERO_A = 3'b000;
  localparam logic [2:0] BOOTH_POS1_A = 3'b001;
  localparam logic [2:0] BOOTH_POS1_B = 3'b010;
  localparam logic [2:0] BOOTH_POS2   = 3'b011;
  localparam logic [2:0] BOOTH_NEG2   = 3'b100;
  localparam logic [2:0] BOOTH_NEG1_A = 3'b101;
  localparam logic [2:0] BOOTH_NEG1_B = 3'b110;
  localparam logic [2:0] BOOTH_ZERO_B = 3'b111;

endpackage

// File: rtl/mult_iter_unit_if.sv
// Decode-side operand handshake and write-back result port of the multiplier.
interface mult_iter_unit_if #(
  parameter int XLEN = 32
);
  logic [XLEN-1:0] OP1_SE;
  logic [XLEN-1:0] OP2_SE;
  logic [1:0]      MULT_CMD_RD;
  logic            DEC2MUL_EMPTY_SD;
  logic            MUL_POP_SM;
  logic            FLUSH_SM;
  logic            MUL2WB_POP_SW;
  logic            MUL2WB_EMPTY_SM;
  logic [XLEN-1:0] RES_RM;
  logic            BUSY_SM;

  modport master (
    output OP1_SE, OP2_SE, MULT_CMD_RD, DEC2MUL_EMPTY_SD, FLUSH_SM, MUL2WB_POP_SW,
    input  MUL_POP_SM, MUL2WB_EMPTY_SM, RES_RM, BUSY_SM
  );

  modport slave (
    input  OP1_SE, OP2_SE, MULT_CMD_RD, DEC2MUL_EMPTY_SD, FLUSH_SM, MUL2WB_POP_SW,
    output MUL_POP_SM, MUL2WB_EMPTY_SM, RES_RM, BUSY_SM
  );
endinterface

// File: rtl/booth_r4_sel.sv
// Radix-4 Booth partial-product select; op1 arrives pre-shifted, so the result wraps at W bits.
module booth_r4_sel
  import mult_pkg::*;
#(
  parameter int W = 68
) (
  input  logic [2:0]   grp,
  input  logic [W-1:0] op1,
  output logic [W-1:0] pp
);

  // Pick 0, +-op1 or +-2*op1 from the three-bit Booth group.
  always_comb begin
    pp = {W{1'b0}};
    case (grp)
      BOOTH_ZERO_A, BOOTH_ZERO_B: pp = {W{1'b0}};
      BOOTH_POS1_A, BOOTH_POS1_B: pp = op1;
      BOOTH_POS2:                 pp = op1 << 1;
      BOOTH_NEG2:                 pp = -(op1 << 1);
      BOOTH_NEG1_A, BOOTH_NEG1_B: pp = -op1;
      default:                    pp = {W{1'b0}};
    endcase
  end

endmodule

// File: rtl/fifo.sv
// Synchronous FIFO with registered head data and registered empty/full flags.
module fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             empty,
  output logic             full
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEPTH);
  localparam logic [PW-1:0] PTR_MAX = PW'(DEPTH - 1);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [PW-1:0]    rd_ptr_r, wr_ptr_r;
  logic [CW-1:0]    count_r, count_next_s;
  logic [WIDTH-1:0] head_r, head_next_s;
  logic             empty_r, full_r, pop_eff_s, push_eff_s;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    if (p == PTR_MAX) return {PW{1'b0}};
    else return p + PW'(1);
  endfunction

  assign pop_eff_s  = pop && !flush && (count_r != {CW{1'b0}});
  assign push_eff_s = push && !flush && ((count_r != CNT_MAX) || pop_eff_s);

  // Occupancy and next head value; a push into an emptying queue goes straight to the head.
  always_comb begin
    count_next_s = count_r;
    head_next_s  = head_r;
    case ({push_eff_s, pop_eff_s})
      2'b10:   count_next_s = count_r + CW'(1);
      2'b01:   count_next_s = count_r - CW'(1);
      default: count_next_s = count_r;
    endcase
    if (pop_eff_s && (count_r > CW'(1))) begin
      head_next_s = mem_r[ptr_inc(rd_ptr_r)];
    end else if (push_eff_s && ((count_r == {CW{1'b0}}) || (pop_eff_s && (count_r == CW'(1))))) begin
      head_next_s = push_data;
    end else begin
      head_next_s = head_r;
    end
  end

  // Pointers, count, head register and flags.
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      rd_ptr_r <= {PW{1'b0}};
      wr_ptr_r <= {PW{1'b0}};
      count_r  <= {CW{1'b0}};
      head_r   <= {WIDTH{1'b0}};
      empty_r  <= 1'b1;
      full_r   <= 1'b0;
    end else begin
      if (pop_eff_s)  rd_ptr_r <= ptr_inc(rd_ptr_r);
      if (push_eff_s) wr_ptr_r <= ptr_inc(wr_ptr_r);
      count_r <= count_next_s;
      head_r  <= head_next_s;
      empty_r <= (count_next_s == {CW{1'b0}});
      full_r  <= (count_next_s == CNT_MAX);
    end
  end

  // Storage array.
  always_ff @(posedge clk) begin
    if (push_eff_s) mem_r[wr_ptr_r] <= push_data;
  end

  assign head  = head_r;
  assign empty = empty_r;
  assign full  = full_r;

endmodule

// File: rtl/mult_iter_unit.sv
// Iterative radix-4 Booth multiplier (MUL/MULH/MULHSU/MULHU) feeding a write-back result FIFO.
// Define MULT_EARLY_OUT_EN to finish as soon as the remaining multiplier groups contribute nothing.
module mult_iter_unit
  import mult_pkg::*;
#(
  parameter int XLEN       = 32,
  parameter int FIFO_DEPTH = 2
) (
  input  logic            clk,
  input  logic            reset,
  mult_iter_unit_if.slave bus
);
  localparam int EXT_W = XLEN + 2;
  localparam int ACC_W = 2 * XLEN + 4;
  localparam int N_IT  = XLEN / 2 + 1;
  localparam int CNT_W = $clog2(N_IT);

  mult_state_t      state_r, state_next_s;
  mult_cmd_t        cmd_r;
  logic [ACC_W-1:0] acc_r, mcand_r, pp_s;
  logic [EXT_W-1:0] mplier_r, mplier_next_s;
  logic             prev_r;
  logic [CNT_W-1:0] cnt_r;
  logic             pop_s, push_s, last_s, op1_sgn_s, op2_sgn_s;
  logic             fifo_full_s, fifo_empty_s, unused_acc_s;
  logic [XLEN-1:0]  res_s, fifo_head_s;

  assign pop_s     = !bus.DEC2MUL_EMPTY_SD && !bus.FLUSH_SM && (state_r == ST_IDLE);
  assign op1_sgn_s = ((bus.MULT_CMD_RD == MULT_MULH) || (bus.MULT_CMD_RD == MULT_MULHSU))
                     && bus.OP1_SE[XLEN-1];
  assign op2_sgn_s = (bus.MULT_CMD_RD == MULT_MULH) && bus.OP2_SE[XLEN-1];

  // Multiplier shifts right two bits per step; its bit 1 becomes the next group's low bit.
  assign mplier_next_s = {{2{mplier_r[EXT_W-1]}}, mplier_r[EXT_W-1:2]};

`ifdef MULT_EARLY_OUT_EN
  assign last_s = (cnt_r == CNT_W'(N_IT - 1)) || (mplier_next_s == {EXT_W{mplier_r[1]}});
`else
  assign last_s = (cnt_r == CNT_W'(N_IT - 1));
`endif

  booth_r4_sel #(.W(ACC_W)) u_booth (
    .grp ({mplier_r[1:0], prev_r}),
    .op1 (mcand_r),
    .pp  (pp_s)
  );

  // Operand capture and one Booth step per CALC cycle; held in DONE.
  always_ff @(posedge clk) begin
    if (reset) begin
      cmd_r    <= MULT_MUL;
      acc_r    <= {ACC_W{1'b0}};
      mcand_r  <= {ACC_W{1'b0}};
      mplier_r <= {EXT_W{1'b0}};
      prev_r   <= 1'b0;
      cnt_r    <= {CNT_W{1'b0}};
    end else if (pop_s) begin
      cmd_r    <= mult_cmd_t'(bus.MULT_CMD_RD);
      acc_r    <= {ACC_W{1'b0}};
      mcand_r  <= {{(ACC_W - XLEN){op1_sgn_s}}, bus.OP1_SE};
      mplier_r <= {{2{op2_sgn_s}}, bus.OP2_SE};
      prev_r   <= 1'b0;
      cnt_r    <= {CNT_W{1'b0}};
    end else if (state_r == ST_CALC) begin
      acc_r    <= acc_r + pp_s;
      mcand_r  <= mcand_r << 2;
      mplier_r <= mplier_next_s;
      prev_r   <= mplier_r[1];
      cnt_r    <= cnt_r + CNT_W'(1);
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state_r <= ST_IDLE;
    else       state_r <= state_next_s;
  end

  // Next-state logic; flush overrides everything.
  always_comb begin
    state_next_s = state_r;
    if (bus.FLUSH_SM) begin
      state_next_s = ST_IDLE;
    end else begin
      case (state_r)
        ST_IDLE: state_next_s = pop_s ? ST_CALC : ST_IDLE;
        ST_CALC: state_next_s = last_s ? ST_DONE : ST_CALC;
        ST_DONE: state_next_s = fifo_full_s ? ST_DONE : ST_IDLE;
        default: state_next_s = ST_IDLE;
      endcase
    end
  end

  assign res_s        = (cmd_r == MULT_MUL) ? acc_r[XLEN-1:0] : acc_r[2*XLEN-1:XLEN];
  assign unused_acc_s = ^acc_r[ACC_W-1:2*XLEN];
  assign push_s       = (state_r == ST_DONE) && !fifo_full_s && !bus.FLUSH_SM;

  fifo #(.WIDTH(XLEN), .DEPTH(FIFO_DEPTH)) u_out_fifo (
    .clk       (clk),
    .reset     (reset),
    .flush     (bus.FLUSH_SM),
    .push      (push_s),
    .push_data (res_s),
    .pop       (bus.MUL2WB_POP_SW),
    .head      (fifo_head_s),
    .empty     (fifo_empty_s),
    .full      (fifo_full_s)
  );

  assign bus.MUL_POP_SM      = pop_s;
  assign bus.MUL2WB_EMPTY_SM = fifo_empty_s;
  assign bus.RES_RM          = fifo_head_s;
  assign bus.BUSY_SM         = (state_r != ST_IDLE);

endmodule
